leaf_stream_packetizer: RTL and testbench

LEAF_STREAM_PACKETIZER -- requirements
Module: leaf_stream_packetizer

---
 rtl/leaf_pkg.sv | 36 +++
 rtl/leaf_credit_counter.sv | 41 ++++
 rtl/leaf_stream_packetizer.sv | 150 +++++++++++++++
 tb/tb_leaf_stream_packetizer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf stream packetizer: FSM encoding,
// packet field layout helpers and the initial credit constant.
package leaf_pkg;

  // Packetizer control states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    CREDIT_WAIT = 2'd2
  } pkt_state_e;

  // Receiver starts empty, so every buffer slot is an available credit.
  function automatic int init_credits(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  // Packet layout, LSB first: payload, addr, dest_port, dest_leaf, valid.
  function automatic int addr_lsb(input int payload_bits);
    return payload_bits;
  endfunction

  function automatic int port_lsb(input int payload_bits, input int addr_bits);
    return payload_bits + addr_bits;
  endfunction

  function automatic int leaf_lsb(input int payload_bits, input int addr_bits,
                                  input int port_bits);
    return payload_bits + addr_bits + port_bits;
  endfunction

  function automatic int valid_pos(input int payload_bits, input int addr_bits,
                                   input int port_bits, input int leaf_bits);
    return payload_bits + addr_bits + port_bits + leaf_bits;
  endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Receiver credit counter: one credit consumed per accepted word, a block of
// credits returned per update pulse, saturating at the receiver depth.
module leaf_credit_counter
  import leaf_pkg::*;
#(
  parameter int CNT_BITS    = 8,
  parameter int MAX_CREDITS = 128,
  parameter int UPDATE_SIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                consume,
  input  logic                update,
  output logic [CNT_BITS-1:0] credits,
  output logic                zero,
  output logic                overflow
);

  localparam int SUM_BITS = CNT_BITS + 2;

  logic [CNT_BITS-1:0] credits_q, credits_d;
  logic [SUM_BITS-1:0] sum;

  // Net change of consume and update in one step; clamp at the receiver depth.
  always_comb begin
    sum       = SUM_BITS'(credits_q)
              + (update  ? SUM_BITS'(UPDATE_SIZE) : SUM_BITS'(0))
              - (consume ? SUM_BITS'(1)           : SUM_BITS'(0));
    overflow  = (sum > SUM_BITS'(MAX_CREDITS));
    credits_d = overflow ? CNT_BITS'(MAX_CREDITS) : sum[CNT_BITS-1:0];
    credits   = credits_q;
    zero      = (credits_q == '0);
  end

  // Credit register.
  always_ff @(posedge clk) begin
    if (reset) credits_q <= CNT_BITS'(MAX_CREDITS);
    else       credits_q <= credits_d;
  end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Wraps user payload words into BFT packets with a static route and a
// rolling receiver address, throttled by receiver credits.
// Optional feature: define LEAF_PKT_STATS_EN to add a 32-bit pkt_count
// output counting packets acknowledged downstream.
module leaf_stream_packetizer
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic                     credit_update,
  output logic [PACKET_BITS-1:0]   pkt_out,
  output logic                     pkt_out_vld,
  input  logic                     pkt_out_ack,
  output logic                     credit_err
`ifdef LEAF_PKT_STATS_EN
  ,
  output logic [31:0]              pkt_count
`endif
);

  localparam int CNT_BITS    = NUM_ADDR_BITS + 1;
  localparam int MAX_CREDITS = init_credits(NUM_ADDR_BITS);
  localparam int ADDR_LSB    = addr_lsb(PAYLOAD_BITS);
  localparam int PORT_LSB    = port_lsb(PAYLOAD_BITS, NUM_ADDR_BITS);
  localparam int LEAF_LSB    = leaf_lsb(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS);
  localparam int VALID_POS   = valid_pos(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS,
                                         NUM_LEAF_BITS);

  pkt_state_e                state_q, state_d;
  logic [PACKET_BITS-1:0]    pkt_out_q, pkt_out_d;
  logic                      pkt_out_vld_q, pkt_out_vld_d;
  logic [NUM_ADDR_BITS-1:0]  addr_q, addr_d;
  logic                      credit_err_q, credit_err_d;
  logic                      accept;
  logic                      last_credit;
  logic [CNT_BITS-1:0]       credits;
  logic                      credits_zero;
  logic                      credits_overflow;

  leaf_credit_counter #(
    .CNT_BITS    (CNT_BITS),
    .MAX_CREDITS (MAX_CREDITS),
    .UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .consume  (accept),
    .update   (credit_update),
    .credits  (credits),
    .zero     (credits_zero),
    .overflow (credits_overflow)
  );

  // Accept when a credit is free and the output slot is empty or draining now.
  always_comb begin
    accept = vld_user2interface && (state_q != CREDIT_WAIT) && !credits_zero
          && (!pkt_out_vld_q || pkt_out_ack) && !reset;
    last_credit = accept && (credits == CNT_BITS'(1)) && !credit_update;
    ack_interface2user = accept;
  end

  // Next-state logic: stall in CREDIT_WAIT once the last credit is spent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = last_credit ? CREDIT_WAIT : SEND;
      end
      SEND: begin
        if (last_credit)                                 state_d = CREDIT_WAIT;
        else if (!pkt_out_vld_q && !vld_user2interface)  state_d = IDLE;
      end
      CREDIT_WAIT: begin
        if (credit_update) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output packet register, address sequencing and sticky overflow flag.
  always_comb begin
    pkt_out_d     = pkt_out_q;
    pkt_out_vld_d = pkt_out_vld_q;
    addr_d        = addr_q;
    credit_err_d  = credit_err_q || credits_overflow;
    if (accept) begin
      pkt_out_d                                = '0;
      pkt_out_d[VALID_POS]                     = 1'b1;
      pkt_out_d[LEAF_LSB +: NUM_LEAF_BITS]     = dest_leaf;
      pkt_out_d[PORT_LSB +: NUM_PORT_BITS]     = dest_port;
      pkt_out_d[ADDR_LSB +: NUM_ADDR_BITS]     = addr_q;
      pkt_out_d[0 +: PAYLOAD_BITS]             = din_leaf_user2interface;
      pkt_out_vld_d                            = 1'b1;
      addr_d                                   = addr_q + 1'b1;
    end else if (pkt_out_ack) begin
      pkt_out_vld_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any held packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pkt_out_q     <= '0;
      pkt_out_vld_q <= 1'b0;
      addr_q        <= '0;
      credit_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_out_q     <= pkt_out_d;
      pkt_out_vld_q <= pkt_out_vld_d;
      addr_q        <= addr_d;
      credit_err_q  <= credit_err_d;
    end
  end

  assign pkt_out     = pkt_out_q;
  assign pkt_out_vld = pkt_out_vld_q;
  assign credit_err  = credit_err_q;

`ifdef LEAF_PKT_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;

  // Count packets taken by the downstream side; free-running wrap.
  always_comb begin
    pkt_count_d = pkt_count_q + ((pkt_out_vld_q && pkt_out_ack) ? 32'd1 : 32'd0);
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (reset) pkt_count_q <= '0;
    else       pkt_count_q <= pkt_count_d;
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Directed bench for leaf_stream_packetizer with a packet scoreboard and a
// reference credit model.
module tb_leaf_stream_packetizer;
  import leaf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [4:0]  dest_leaf;
  logic [3:0]  dest_port;
  logic        credit_update;
  logic [48:0] pkt_out;
  logic        pkt_out_vld;
  logic        pkt_out_ack;
  logic        credit_err;
`ifdef LEAF_PKT_STATS_EN
  logic [31:0] pkt_count;
`endif

  always #5 clk = ~clk;

  leaf_stream_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .dest_leaf               (dest_leaf),
    .dest_port               (dest_port),
    .credit_update           (credit_update),
    .pkt_out                 (pkt_out),
    .pkt_out_vld             (pkt_out_vld),
    .pkt_out_ack             (pkt_out_ack),
    .credit_err              (credit_err)
`ifdef LEAF_PKT_STATS_EN
    ,
    .pkt_count               (pkt_count)
`endif
  );

  logic [48:0] sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          exp_credits;
  logic        exp_err;
  logic [6:0]  exp_addr;
  logic [31:0] next_word;
  int          accepted;
  int          popped;
  logic [6:0]  pop129_addr;
  logic        got_ack;
  logic [48:0] held;
  logic [48:0] exp_pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  // One clock: sample at negedge, score outputs, update models, then advance.
  task automatic cycle();
    @(negedge clk);
    got_ack = ack_interface2user;
    if (pkt_out_vld && pkt_out_ack) begin
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_pkt = sb_q.pop_front();
        check("pkt_out", 64'(pkt_out), 64'(exp_pkt));
      end
      popped++;
      if (popped == 129) pop129_addr = pkt_out[38:32];
    end
    if (got_ack) begin
      sb_q.push_back(mk(dest_leaf, dest_port, exp_addr, din_leaf_user2interface));
      exp_addr++;
      accepted++;
      exp_credits--;
    end
    if (credit_update) begin
      exp_credits += 64;
      if (exp_credits > 128) begin
        exp_credits = 128;
        exp_err     = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (got_ack) next_word++;
  endtask

  task automatic stream(input int n);
    vld_user2interface = 1'b1;
    repeat (n) begin
      din_leaf_user2interface = next_word;
      cycle();
    end
  endtask

  task automatic idle(input int n);
    vld_user2interface = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    vld_user2interface = 1'b0;
    credit_update      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    exp_addr    = '0;
    exp_credits = 128;
    exp_err     = 1'b0;
    popped      = 0;
    accepted    = 0;
  endtask

  initial begin
    din_leaf_user2interface = '0;
    dest_leaf     = 5'd3;
    dest_port     = 4'd2;
    pkt_out_ack   = 1'b1;
    next_word     = 32'h1;
    pop129_addr   = 7'h7f;

    // Reset state.
    do_reset();
    check("rst_vld", 64'(pkt_out_vld), 64'd0);
    check("rst_pkt", 64'(pkt_out), 64'd0);
    check("rst_ack", 64'(ack_interface2user), 64'd0);
    check("rst_err", 64'(credit_err), 64'd0);
    check("rst_credits", 64'(dut.credits), 64'd128);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));

    // Five words 0x1..0x5 to leaf 3 port 2 at full rate.
    vld_user2interface      = 1'b1;
    din_leaf_user2interface = next_word;
    cycle();
    check("first_accept", 64'(got_ack), 64'd1);
    check("first_latency_vld", 64'(pkt_out_vld), 64'd1);
    check("first_pkt", 64'(pkt_out), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'h1}));
    stream(4);
    check("b2b_accepted", 64'(accepted), 64'd5);
    idle(3);
    check("five_popped", 64'(popped), 64'd5);
    check("five_sb_empty", 64'(sb_q.size()), 64'd0);
    check("five_state_idle", 64'(dut.state_q), 64'(IDLE));
    check("five_credits", 64'(dut.credits), 64'(exp_credits));

    // Exhaust credits, then one update releases 64 more; address wraps.
    do_reset();
    stream(140);
    check("exhaust_accepted", 64'(accepted), 64'd128);
    check("exhaust_state", 64'(dut.state_q), 64'(CREDIT_WAIT));
    check("exhaust_ack_low", 64'(ack_interface2user), 64'd0);
    check("exhaust_credits", 64'(dut.credits), 64'd0);
    credit_update = 1'b1;
    cycle();
    credit_update = 1'b0;
    check("update_state", 64'(dut.state_q), 64'(SEND));
    stream(80);
    check("update_accepted", 64'(accepted), 64'd192);
    check("update_state_wait", 64'(dut.state_q), 64'(CREDIT_WAIT));
    idle(3);
    check("update_popped", 64'(popped), 64'd192);
    check("wrap_addr_129", 64'(pop129_addr), 64'd0);
    check("update_credits", 64'(dut.credits), 64'(exp_credits));

    // Downstream backpressure for 10 cycles.
    do_reset();
    pkt_out_ack = 1'b0;
    stream(1);
    check("bp_first_accept", 64'(accepted), 64'd1);
    held = pkt_out;
    for (int i = 0; i < 10; i++) begin
      din_leaf_user2interface = next_word;
      cycle();
      check("bp_hold_pkt", 64'(pkt_out), 64'(held));
      check("bp_no_accept", 64'(got_ack), 64'd0);
    end
    pkt_out_ack = 1'b1;
    stream(10);
    idle(3);
    check("bp_accepted", 64'(accepted), 64'd11);
    check("bp_popped", 64'(popped), 64'd11);
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Over-return of credits saturates and sets the sticky error.
    do_reset();
    stream(28);
    idle(2);
    check("sat_credits_100", 64'(dut.credits), 64'd100);
    credit_update = 1'b1;
    cycle();
    credit_update = 1'b0;
    check("sat_credits", 64'(dut.credits), 64'(exp_credits));
    check("sat_credits_128", 64'(dut.credits), 64'd128);
    check("sat_err", 64'(credit_err), 64'(exp_err));
    idle(5);
    check("sat_err_sticky", 64'(credit_err), 64'd1);

    // Reset while a packet is held.
    pkt_out_ack = 1'b0;
    stream(2);
    check("midrst_vld_before", 64'(pkt_out_vld), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_vld", 64'(pkt_out_vld), 64'd0);
    check("midrst_credits", 64'(dut.credits), 64'd128);
    check("midrst_addr", 64'(dut.addr_q), 64'd0);
    check("midrst_err", 64'(credit_err), 64'd0);
    check("midrst_ack", 64'(ack_interface2user), 64'd0);
    do_reset();
    pkt_out_ack = 1'b1;
    idle(3);
    check("midrst_no_partial", 64'(popped), 64'd0);
    check("midrst_state", 64'(dut.state_q), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
